a2d_arbiter: RTL and testbench
==============================

// Module: a2d_arbiter
//
// PURPOSE
//   Shares the single A2D_intf/SPI A2D channel path among NUM_REQ requesters.
//   Example requesters: the slider scanner, a battery monitor and a test hook.
//   Each requester posts a 3-bit channel and a request. The arbiter grants one
//   requester at a time, in round-robin order. For each grant it drives one
//   strt_cnv pulse to A2D_intf, then returns the 12-bit result to the granted
//   requester together with a done pulse. It sits between the requesters and
//   A2D_intf, and is the only driver of strt_cnv and chnnl.
//
// PARAMETERS
//   NUM_REQ      4     number of requesters (2..8)
//   TIMEOUT_CYC  4096  WAIT-state abort limit in clk cycles (ARB_TIMEOUT_EN only)
//
// PORTS
//   clk          in   1          system clock
//   rst_n        in   1          synchronous active-low reset, sampled on posedge clk
//   req          in   NUM_REQ    per-requester conversion request, level
//   req_chnnl    in   3*NUM_REQ  channel of requester i in bits [3i+2:3i]
//   gnt          out  NUM_REQ    one-hot grant, held from START through WAIT
//   done         out  NUM_REQ    one-cycle pulse to the granted requester; res valid
//   res          out  12         last conversion result, held until next done
//   busy         out  1          high in START or WAIT
//   timeout_err  out  1          one-cycle pulse on WAIT abort (0 when macro off)
//   strt_cnv     out  1          to A2D_intf: start conversion, one-cycle pulse
//   chnnl        out  3          to A2D_intf: channel, stable from START until done
//   cnv_cmplt    in   1          from A2D_intf: conversion complete
//   a2d_res      in   12         from A2D_intf: result, valid with cnv_cmplt
//
// BEHAVIOUR
//   Reset values
//   - Reset is synchronous: state IDLE, ptr=0, counter=0.
//   - All outputs are 0 out of reset: gnt, done, res, busy, timeout_err,
//     strt_cnv, chnnl.
//   State machine (all outputs registered)
//   - IDLE, when any req bit is set:
//     - Pick winner w = the first set req bit at or above ptr, wrapping at NUM_REQ.
//     - Latch chnnl <= req_chnnl[w]. Set gnt[w] and strt_cnv. Go to START.
//   - START: strt_cnv is high for exactly this cycle. Go to WAIT.
//   - WAIT, when cnv_cmplt is seen:
//     - res <= a2d_res. done[w] <= 1 for one cycle. gnt <= 0.
//     - ptr <= (w+1) mod NUM_REQ. Go to IDLE.
//   Latency
//   - A request sampled in IDLE at cycle N gives gnt and strt_cnv at N+1.
//   - cnv_cmplt at cycle M gives done and res at M+1.
//   - A pending request is sampled in IDLE at M+1 and granted at M+2.
//   Channels and requests
//   - Channels are not range-checked. Codes 5 and 6 are passed through unchanged.
//   - req/req_chnnl changes during START/WAIT are ignored. The latched chnnl is used.
//   - Dropping req mid-conversion does not abort. done still pulses and ptr
//     still advances.
//   - Fairness: a continuously asserting requester cannot be granted twice
//     while another req bit is set.
//   - A cnv_cmplt received in IDLE or START is ignored.
//   - Reset mid-conversion: everything returns to reset values on the next edge.
//     A2D_intf shares rst_n, so its transaction is also dropped.
//   - At most one gnt bit and one done bit are high in any cycle.
//
// CONFIGURATION
//   ARB_TIMEOUT_EN defined
//   - A counter clears on entering WAIT and increments on each WAIT cycle.
//   - If it reaches TIMEOUT_CYC-1 without cnv_cmplt:
//     - res <= 12'hFFF; done[w] and timeout_err pulse together.
//     - ptr advances, gnt <= 0, go to IDLE.
//   - If cnv_cmplt arrives on the same cycle as the limit, cnv_cmplt wins:
//     normal completion and no error.
//   ARB_TIMEOUT_EN undefined
//   - WAIT waits indefinitely. timeout_err is tied 0. The counter is not built.
//
// TESTING
//   1. Only req[0] set with chnnl 3'b010. A2D model returns 12'hA5C after 40 cycles.
//      Required: strt_cnv pulses once, chnnl=2 until done[0], res=12'hA5C, busy
//      low in the cycle after done.
//   2. All req bits held high, four conversions.
//      Required: gnt order 0,1,2,3. Each grant sees exactly one strt_cnv. done
//      order matches the grants.
//   3. req[1] and req[3] set after a grant to 1.
//      Required: the next grant goes to 3, then to 1. A lone req[2] arriving
//      during WAIT is granted at M+2.
//   4. req_chnnl[0] changed from 4 to 7 during WAIT, and req[0] dropped.
//      Required: chnnl stays 4, done[0] still pulses.
//   5. rst_n low for one cycle during WAIT.
//      Required: all outputs 0 the next cycle. A new req is then granted normally.
//   6. ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16, cnv_cmplt never arrives.
//      Required: done and timeout_err at cycle 16 of WAIT, res=12'hFFF.
//      With cnv_cmplt on the limit cycle: no timeout_err.

Source files
------------

// File: rtl/a2d_arbiter.sv
// ---------------------------------------------------------------------------
// a2d_arbiter
//
// Purpose
//   Lets NUM_REQ requesters share the single A2D_intf conversion path, for
//   example a slider scanner, a battery monitor and a test hook. Grants go
//   out round-robin. Each grant issues exactly one strt_cnv pulse. The
//   12-bit result then goes back to the granted requester with a one-cycle
//   done pulse. This block is the only driver of strt_cnv and chnnl.
//
// Handshake
//   A requester holds req[i] as a level. It is granted when gnt[i] rises.
//   Its result is valid in res while done[i] is high for one cycle. Toward
//   A2D_intf, strt_cnv is a one-cycle command. cnv_cmplt is a one-cycle
//   response qualifying a2d_res. Any cnv_cmplt seen outside WAIT is dropped.
//
// Optional feature (macro ARB_TIMEOUT_EN)
//   When defined, WAIT aborts after TIMEOUT_CYC cycles without cnv_cmplt.
//   The abort returns res = 12'hFFF and pulses done[w] together with
//   timeout_err. A cnv_cmplt on the limit cycle takes priority over the
//   abort. When undefined, WAIT waits forever and timeout_err stays 0.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   req          in   [NUM_REQ]    per-requester request level
//   req_chnnl    in   [3*NUM_REQ]  channel of requester i at [3i+2:3i]
//   gnt          out  [NUM_REQ]    one-hot grant, START through WAIT
//   done         out  [NUM_REQ]    one-cycle completion pulse, res valid
//   res          out  [12]         last result, held until next done
//   busy         out  high in START or WAIT
//   timeout_err  out  one-cycle pulse on WAIT abort
//   strt_cnv     out  one-cycle start pulse to A2D_intf
//   chnnl        out  [3]          latched channel to A2D_intf
//   cnv_cmplt    in   conversion complete from A2D_intf
//   a2d_res      in   [12]         result from A2D_intf
//
// The FSM state is held in the internal signal 'state' (type state_t) so
// that checkers can bind to it.
// ---------------------------------------------------------------------------
module a2d_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_chnnl,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [11:0]            res,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   strt_cnv,
    output logic [2:0]             chnnl,
    input  logic                   cnv_cmplt,
    input  logic [11:0]            a2d_res
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [PTR_W-1:0]   ptr, ptr_d;      // round-robin search start
    logic [PTR_W-1:0]   cur, cur_d;      // index of the current grant
    logic [PTR_W-1:0]   ptr_next;        // ptr value after current grant
    logic [PTR_W-1:0]   win;             // round-robin winner this cycle
    logic [PTR_W-1:0]   idx;
    logic               found;
    int                 sum;

    logic [NUM_REQ-1:0] gnt_d, done_d;
    logic [11:0]        res_d;
    logic               busy_d, strt_d, to_d;
    logic [2:0]         chnnl_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]   cnt, cnt_d;
`else
    // TIMEOUT_CYC has no function when the abort counter is not built.
    logic               unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // Round-robin winner: first set req bit at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = 0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = PTR_W'(sum);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign ptr_next = (cur == PTR_W'(NUM_REQ - 1)) ? '0 : cur + 1'b1;

    // Next-state and next-output logic. Every output is registered below.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cur_d   = cur;
        gnt_d   = gnt;
        done_d  = '0;
        res_d   = res;
        busy_d  = busy;
        strt_d  = 1'b0;
        to_d    = 1'b0;
        chnnl_d = chnnl;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_d = START;
                    cur_d   = win;
                    gnt_d   = NUM_REQ'(1) << win;
                    strt_d  = 1'b1;
                    busy_d  = 1'b1;
                    chnnl_d = req_chnnl[3*win +: 3];
                end
            end
            START: begin
                state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // gnt already holds the one-hot of cur, so it doubles as done.
                if (cnv_cmplt) begin
                    state_d = IDLE;
                    res_d   = a2d_res;
                    done_d  = gnt;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                    res_d   = 12'hFFF;
                    done_d  = gnt;
                    to_d    = 1'b1;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                end else begin
                    cnt_d   = cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            cur         <= '0;
            gnt         <= '0;
            done        <= '0;
            res         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            strt_cnv    <= 1'b0;
            chnnl       <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            cur         <= cur_d;
            gnt         <= gnt_d;
            done        <= done_d;
            res         <= res_d;
            busy        <= busy_d;
            timeout_err <= to_d;
            strt_cnv    <= strt_d;
            chnnl       <= chnnl_d;
`ifdef ARB_TIMEOUT_EN
            cnt         <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_a2d_arbiter.sv
// ---------------------------------------------------------------------------
// tb_a2d_arbiter
//
// Directed bench for a2d_arbiter (NUM_REQ = 4, TIMEOUT_CYC = 16). Each
// grant pushes {gnt, chnnl} into gnt_q. Each completion pushes
// {done, res, timeout_err} into exp_q. A monitor running on the falling
// edge pops and compares these whenever strt_cnv or done is seen. The
// timeout scenario is compiled only when ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_a2d_arbiter;

    localparam int NR = 4;
    localparam int TO = 16;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [3*NR-1:0] req_chnnl;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic [11:0]     res;
    logic            busy;
    logic            timeout_err;
    logic            strt_cnv;
    logic [2:0]      chnnl;
    logic            cnv_cmplt;
    logic [11:0]     a2d_res;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0]  gnt_q[$];   // {gnt, chnnl}
    logic [16:0] exp_q[$];   // {done, res, timeout_err}

    a2d_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_chnnl   (req_chnnl),
        .gnt         (gnt),
        .done        (done),
        .res         (res),
        .busy        (busy),
        .timeout_err (timeout_err),
        .strt_cnv    (strt_cnv),
        .chnnl       (chnnl),
        .cnv_cmplt   (cnv_cmplt),
        .a2d_res     (a2d_res)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_gnt(input int i, input logic [2:0] ch);
        gnt_q.push_back({4'(1 << i), ch});
    endtask

    task automatic push_done(input int i, input logic [11:0] val, input logic to);
        exp_q.push_back({4'(1 << i), val, to});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (strt_cnv) begin
            if (gnt_q.size() == 0) begin
                n_checks++;
                $display("FAIL grant_unexpected: got gnt=%b chnnl=%0d with nothing expected", gnt, chnnl);
            end else begin
                check("grant", {25'd0, gnt, chnnl}, {25'd0, gnt_q.pop_front()});
            end
        end
        if (done != '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL done_unexpected: got done=%b res=%0h with nothing expected", done, res);
            end else begin
                check("done_res", {15'd0, done, res, timeout_err}, {15'd0, exp_q.pop_front()});
            end
        end
        check("gnt_onehot",  32'($countones(gnt)  <= 1), 32'd1);
        check("done_onehot", 32'($countones(done) <= 1), 32'd1);
        check("busy_vs_gnt", {31'd0, busy}, {31'd0, |gnt});
        check("to_has_done", {31'd0, timeout_err && (done == '0)}, 32'd0);
    end

    // ---------------- driver tasks ----------------
    // Returns at the falling edge where strt_cnv is high (bounded wait).
    task automatic wait_strt(output bit ok);
        ok = 1'b0;
        if (strt_cnv) begin
            ok = 1'b1;
            return;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (strt_cnv) begin
                ok = 1'b1;
                return;
            end
        end
        n_checks++;
        $display("FAIL strt_timeout: got no strt_cnv within 20 cycles, expected one");
    endtask

    // Serves one conversion as the A2D model. After START it applies
    // req_mid/ch_mid. It answers after lat cycles. It returns on the
    // falling edge where done is visible, having applied req_after.
    task automatic convert(input int lat, input logic [11:0] val, input logic [2:0] exp_ch,
                           input logic [NR-1:0] req_mid, input logic [3*NR-1:0] ch_mid,
                           input logic [NR-1:0] req_after, input bit stray);
        bit ok, stable, extra, busy_ok;
        wait_strt(ok);
        if (!ok) return;
        req       = req_mid;
        req_chnnl = ch_mid;
        if (stray) begin
            cnv_cmplt = 1'b1;       // arrives during START, must be ignored
            a2d_res   = 12'h0BD;
        end
        stable  = 1'b1;
        extra   = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (chnnl !== exp_ch) stable = 1'b0;
            if (strt_cnv) extra = 1'b1;
            if (!busy) busy_ok = 1'b0;
        end
        cnv_cmplt = 1'b1;
        a2d_res   = val;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        a2d_res   = 12'h000;
        req       = req_after;
        if (chnnl !== exp_ch) stable = 1'b0;
        check("chnnl_stable", {31'd0, stable}, 32'd1);
        check("strt_once", {31'd0, extra}, 32'd0);
        check("busy_in_wait", {31'd0, busy_ok}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [3*NR-1:0] chs;
    bit              ok;
    int              cyc;

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_chnnl = '0;
        cnv_cmplt = 1'b0;
        a2d_res   = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {6'd0, gnt, done, res, busy, timeout_err, strt_cnv, chnnl}, 32'd0);
        rst_n = 1'b1;

        // 1: single requester, channel 2, result A5C after 40 cycles
        @(negedge clk);
        req_chnnl = 12'b000_000_000_010;
        req       = 4'b0001;
        push_gnt(0, 3'd2);
        push_done(0, 12'hA5C, 1'b0);
        @(negedge clk);
        check("t1_latency", {27'd0, gnt, strt_cnv}, {27'd0, 4'b0001, 1'b1});
        convert(40, 12'hA5C, 3'd2, 4'b0001, req_chnnl, 4'b0000, 1'b0);
        @(negedge clk);
        check("t1_idle_after_done", {27'd0, gnt, busy}, 32'd0);
        // stray cnv_cmplt in IDLE: no done, res unchanged
        cnv_cmplt = 1'b1;
        a2d_res   = 12'h0EE;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        check("idle_stray", {16'd0, done, res}, {16'd0, 4'b0000, 12'hA5C});

        // 2: all requesters, fresh ptr, grant order 0,1,2,3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chs       = {3'd3, 3'd6, 3'd5, 3'd1};
        req_chnnl = chs;
        req       = 4'b1111;
        push_gnt(0, 3'd1); push_done(0, 12'h123, 1'b0);
        push_gnt(1, 3'd5); push_done(1, 12'h456, 1'b0);
        push_gnt(2, 3'd6); push_done(2, 12'h789, 1'b0);
        push_gnt(3, 3'd3); push_done(3, 12'hABC, 1'b0);
        convert(3, 12'h123, 3'd1, 4'b1111, chs, 4'b1111, 1'b0);
        convert(5, 12'h456, 3'd5, 4'b1111, chs, 4'b1111, 1'b1);
        convert(1, 12'h789, 3'd6, 4'b1111, chs, 4'b1111, 1'b0);
        convert(7, 12'hABC, 3'd3, 4'b1111, chs, 4'b0000, 1'b0);

        // 3: grant 1, then 1 and 3 pending -> 3 then 1; lone 2 at M+2
        @(negedge clk);
        req = 4'b0010;
        push_gnt(1, 3'd5); push_done(1, 12'h111, 1'b0);
        push_gnt(3, 3'd3); push_done(3, 12'h222, 1'b0);
        push_gnt(1, 3'd5); push_done(1, 12'h333, 1'b0);
        push_gnt(2, 3'd6); push_done(2, 12'h444, 1'b0);
        convert(6, 12'h111, 3'd5, 4'b1010, chs, 4'b1010, 1'b0);
        convert(4, 12'h222, 3'd3, 4'b0010, chs, 4'b0010, 1'b0);
        convert(5, 12'h333, 3'd5, 4'b0100, chs, 4'b0100, 1'b0);
        check("t3_gnt_in_done_cycle", {28'd0, gnt}, 32'd0);
        @(negedge clk);
        check("t3_grant_m2", {27'd0, gnt, strt_cnv}, {27'd0, 4'b0100, 1'b1});
        convert(3, 12'h444, 3'd6, 4'b0000, chs, 4'b0000, 1'b0);

        // 4: channel changed and req dropped during WAIT
        @(negedge clk);
        chs       = {3'd3, 3'd6, 3'd5, 3'd4};
        req_chnnl = chs;
        req       = 4'b0001;
        push_gnt(0, 3'd4); push_done(0, 12'h555, 1'b0);
        convert(8, 12'h555, 3'd4, 4'b0000, {3'd3, 3'd6, 3'd5, 3'd7}, 4'b0000, 1'b0);

        // 5: reset during WAIT, then ptr back at 0
        @(negedge clk);
        req = 4'b0100;
        push_gnt(2, 3'd6);
        wait_strt(ok);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_reset_outputs", {6'd0, gnt, done, res, busy, timeout_err, strt_cnv, chnnl}, 32'd0);
        rst_n = 1'b1;
        req   = 4'b1001;
        push_gnt(0, 3'd7); push_done(0, 12'h666, 1'b0);
        convert(5, 12'h666, 3'd7, 4'b0000, req_chnnl, 4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // 6: no cnv_cmplt -> abort with FFF; then cnv_cmplt on the limit cycle
        @(negedge clk);
        req = 4'b1000;
        push_gnt(3, 3'd3); push_done(3, 12'hFFF, 1'b1);
        wait_strt(ok);
        req = 4'b0000;
        cyc = 0;
        for (int i = 0; i < TO + 10; i++) begin
            @(negedge clk);
            cyc++;
            if (done != '0) break;
        end
        check("t6_timeout_cycle", 32'(cyc), 32'(TO + 1));
        check("t6_timeout_res", {19'd0, res, timeout_err}, {19'd0, 12'hFFF, 1'b1});
        @(negedge clk);
        req = 4'b1000;
        push_gnt(3, 3'd3); push_done(3, 12'h777, 1'b0);
        convert(TO, 12'h777, 3'd3, 4'b0000, req_chnnl, 4'b0000, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
